// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, oversampled mid-bit sampling,
// one-cycle data_valid / framing_error strobes.
module uart_rx_core #(
  parameter int NO_OF_DATABITS = 8,
  parameter int NO_OF_STOPBITS = 1,
  parameter int BAUDRATE       = 9600,
  parameter int FREQUENCY      = 100000000,
  parameter int OVERSAMPLE     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  output logic [NO_OF_DATABITS-1:0] data_out,
  output logic                      data_valid,
  output logic                      framing_error,
  output logic                      busy
);

  localparam int DIV  = FREQUENCY / (BAUDRATE * OVERSAMPLE);
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW   = $clog2(OVERSAMPLE);
  localparam int MAXB = (NO_OF_DATABITS > NO_OF_STOPBITS) ?
                        NO_OF_DATABITS : NO_OF_STOPBITS;
  localparam int BW   = (MAXB > 1) ? $clog2(MAXB) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] D_LAST = BW'(NO_OF_DATABITS - 1);
  localparam logic [BW-1:0] S_LAST = BW'(NO_OF_STOPBITS - 1);

  logic [1:0]                state;
  logic                      rx_m;
  logic                      rx_s;
  logic                      rx_d;
  logic [PW-1:0]             presc;
  logic                      tick;
  logic [TW-1:0]             tick_cnt;
  logic [BW-1:0]             bit_cnt;
  logic [NO_OF_DATABITS-1:0] shift_reg;
  logic [NO_OF_DATABITS-1:0] shift_nxt;
  logic                      stop_bad;

  // Idle-high line: synchroniser and edge flop reset to 1 so no false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // Held clear in IDLE so tick phase follows the start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (state == IDLE || presc == P_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = (state != IDLE) && (presc == P_LAST);
  assign busy = (state != IDLE);

  if (NO_OF_DATABITS == 1) begin : g_one
    assign shift_nxt = rx_s;
  end else begin : g_many
    assign shift_nxt = {rx_s, shift_reg[NO_OF_DATABITS-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      stop_bad      <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s && rx_d) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == T_MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == T_LAST) begin
              tick_cnt  <= '0;
              shift_reg <= shift_nxt;
              if (bit_cnt == D_LAST) begin
                bit_cnt  <= '0;
                stop_bad <= 1'b0;
                state    <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tick_cnt == T_LAST) begin
              tick_cnt <= '0;
              // Leave at mid-stop so a back-to-back start edge is seen.
              if (bit_cnt == S_LAST) begin
                bit_cnt <= '0;
                state   <= IDLE;
                if (stop_bad || !rx_s) begin
                  framing_error <= 1'b1;
                end else begin
                  data_out   <= shift_reg;
                  data_valid <= 1'b1;
                end
              end else begin
                bit_cnt  <= bit_cnt + 1'b1;
                stop_bad <= stop_bad | ~rx_s;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: frame-level model predicts strobe cycle and
// payload; a negedge process compares both receiver instances.
module tb_uart_rx_core;

  localparam int DIV  = 4;
  localparam int OS   = 16;
  localparam int BIT  = OS * DIV;
  localparam int HALF = (OS / 2) * DIV;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx1   = 1'b1;
  logic       rx2   = 1'b1;
  logic [7:0] dout1, dout2;
  logic       dv1, dv2, fe1, fe2, busy1, busy2;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int last_dv1 = -1, last_fe1 = -1;
  int last_dv2 = -1, last_fe2 = -1;
  logic [7:0] md1 = 8'h00;
  logic [7:0] md2 = 8'h00;

  typedef struct {
    int         cyc;
    bit         fe;
    logic [7:0] data;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  uart_rx_core #(
    .NO_OF_DATABITS(8), .NO_OF_STOPBITS(1),
    .BAUDRATE(1), .FREQUENCY(64), .OVERSAMPLE(16)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx1),
    .data_out(dout1), .data_valid(dv1),
    .framing_error(fe1), .busy(busy1)
  );

  uart_rx_core #(
    .NO_OF_DATABITS(8), .NO_OF_STOPBITS(2),
    .BAUDRATE(1), .FREQUENCY(64), .OVERSAMPLE(16)
  ) dut2 (
    .clk(clk), .reset(reset), .rx(rx2),
    .data_out(dout2), .data_valid(dv2),
    .framing_error(fe2), .busy(busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic ev, ef;
    logic [7:0] ed;
    if (reset) begin
      md1 = 8'h00;
      md2 = 8'h00;
    end else begin
      ev = 1'b0; ef = 1'b0; ed = md1;
      while (q1.size() > 0 && q1[0].cyc < cyc) void'(q1.pop_front());
      if (q1.size() > 0 && q1[0].cyc == cyc) begin
        e = q1.pop_front();
        ef = e.fe; ev = !e.fe;
        if (ev) ed = e.data;
      end
      chk("dv1", 32'(dv1), 32'(ev));
      chk("fe1", 32'(fe1), 32'(ef));
      if (ev || dv1) chk("dout1", 32'(dout1), 32'(ed));
      if (ev) md1 = ed;
      if (dv1) last_dv1 = cyc;
      if (fe1) last_fe1 = cyc;

      ev = 1'b0; ef = 1'b0; ed = md2;
      while (q2.size() > 0 && q2[0].cyc < cyc) void'(q2.pop_front());
      if (q2.size() > 0 && q2[0].cyc == cyc) begin
        e = q2.pop_front();
        ef = e.fe; ev = !e.fe;
        if (ev) ed = e.data;
      end
      chk("dv2", 32'(dv2), 32'(ev));
      chk("fe2", 32'(fe2), 32'(ef));
      if (ev || dv2) chk("dout2", 32'(dout2), 32'(ed));
      if (ev) md2 = ed;
      if (dv2) last_dv2 = cyc;
      if (fe2) last_fe2 = cyc;
    end
  end

  task automatic drive(input int u, input logic b, input int n);
    if (u == 1) rx1 = b;
    else rx2 = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Strobe lands 3 sync/edge cycles + half a start bit + data and stop
  // bits after the falling edge; any low stop bit means framing error.
  task automatic send(input int u, input logic [7:0] d,
                      input logic [1:0] stp, output int t0);
    exp_t e;
    int s;
    s = (u == 1) ? 1 : 2;
    t0 = cyc;
    e.cyc  = t0 + 3 + HALF + (8 + s) * BIT;
    e.fe   = (u == 1) ? !stp[0] : !(stp[0] && stp[1]);
    e.data = d;
    if (u == 1) q1.push_back(e);
    else q2.push_back(e);
    drive(u, 1'b0, BIT);
    chk("busy_mid", 32'((u == 1) ? busy1 : busy2), 32'd1);
    for (int i = 0; i < 8; i++) drive(u, d[i], BIT);
    for (int i = 0; i < s; i++) drive(u, stp[i], BIT);
    chk("busy_after", 32'((u == 1) ? busy1 : busy2), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dout1"}, 32'(dout1), 32'd0);
    chk({tag, "_dv1"}, 32'(dv1), 32'd0);
    chk({tag, "_fe1"}, 32'(fe1), 32'd0);
    chk({tag, "_busy1"}, 32'(busy1), 32'd0);
    chk({tag, "_dout2"}, 32'(dout2), 32'd0);
    chk({tag, "_busy2"}, 32'(busy2), 32'd0);
  endtask

  initial begin
    int t;
    logic [7:0] ab;
    repeat (4) @(posedge clk);
    #1;
    chk_reset_vals("rst0");
    reset = 1'b0;
    drive(1, 1'b1, 2 * BIT);
    chk("idle_busy", 32'(busy1), 32'd0);

    send(1, 8'hA5, 2'b11, t);
    chk("a5_data", 32'(dout1), 32'hA5);
    chk("a5_lat", 32'(last_dv1 - t), 32'd611);
    drive(1, 1'b1, BIT);

    send(1, 8'h00, 2'b11, t);
    send(1, 8'hFF, 2'b11, t);
    chk("b2b_data", 32'(dout1), 32'hFF);
    drive(1, 1'b1, BIT);

    drive(1, 1'b0, 20);
    drive(1, 1'b1, 2 * BIT);
    chk("glitch_busy", 32'(busy1), 32'd0);
    chk("glitch_data", 32'(dout1), 32'hFF);

    send(1, 8'h3C, 2'b00, t);
    drive(1, 1'b0, 3 * BIT);
    chk("break_busy", 32'(busy1), 32'd0);
    chk("fe_lat", 32'(last_fe1 - t), 32'd611);
    chk("fe_data", 32'(dout1), 32'hFF);
    drive(1, 1'b1, BIT);
    send(1, 8'hC3, 2'b11, t);
    chk("c3_data", 32'(dout1), 32'hC3);
    drive(1, 1'b1, BIT);

    ab = 8'h77;
    drive(1, 1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(1, ab[i], BIT);
    drive(1, ab[4], 30);
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    rx1 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1, 1'b1, 3 * BIT);
    chk("post_rst_data", 32'(dout1), 32'h00);
    chk("post_rst_busy", 32'(busy1), 32'd0);
    send(1, 8'h5A, 2'b11, t);
    chk("5a_data", 32'(dout1), 32'h5A);

    drive(2, 1'b1, BIT);
    send(2, 8'h81, 2'b01, t);
    chk("s2_fe_lat", 32'(last_fe2 - t), 32'd675);
    chk("s2_fe_data", 32'(dout2), 32'h00);
    drive(2, 1'b1, BIT);
    send(2, 8'h81, 2'b11, t);
    chk("s2_data", 32'(dout2), 32'h81);
    chk("s2_lat", 32'(last_dv2 - t), 32'd675);

    drive(1, 1'b1, BIT);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    chk("q2_empty", 32'(q2.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
